// File: rtl/stencil_pkg.sv
// Shared types and constants for the stencil output collector.
//   BW, ST, TILES  : result word width, row words per capture, results per row word
//   result_set_t   : the six results of one capture, in1 at index 0
//   row_word_t     : one packed row word toward the output RAM writer
//   out_state_e    : output serializer states
package stencil_pkg;

  localparam int unsigned BW    = 32;
  localparam int unsigned ST    = 3;
  localparam int unsigned TILES = 2;

  typedef logic [ST*TILES-1:0][BW-1:0] result_set_t;
  typedef logic [TILES*BW-1:0]         row_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW0 = 2'd1,
    ROW1 = 2'd2,
    ROW2 = 2'd3
  } out_state_e;

endpackage

// File: rtl/collector_fifo.sv
// Capture FIFO for the stencil output collector.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   push, pop, din        : write/read strobes (already qualified by the caller) and write data
//   full, empty, count    : occupancy derived from the extended-width pointers
//   head                  : entry at the read pointer
//   head_after_pop        : entry that becomes the head once the current head is popped
module collector_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 192
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head,
  output logic [W-1:0]             head_after_pop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  rd_next;
  logic [W-1:0] mem [DEPTH];

  // Pointer update; the extra MSB separates full from empty
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; contents are only visible once written
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_comb begin
    count   = wr_ptr - rd_ptr;
    full    = (count == (AW+1)'(DEPTH));
    empty   = (wr_ptr == rd_ptr);
    rd_next = rd_ptr + (AW+1)'(1);
    head    = mem[rd_ptr[AW-1:0]];
    // With a single entry and a push this cycle, the next head is still in flight
    head_after_pop = (count == (AW+1)'(1) && push) ? din : mem[rd_next[AW-1:0]];
  end

endmodule

// File: rtl/stencil_output_collector.sv
// Captures six stencil results per datapath strobe into a FIFO and serializes
// each capture as ST row words onto a valid/ready stream.
//   clock, reset                  : rising-edge clock, synchronous active-high reset
//   io_datapath_valid_in          : capture strobe
//   io_datapath_data_in1..6       : results; row r = {in(2r+2), in(2r+1)}
//   io_out_valid/ready/data       : row word stream
//   io_out_row                    : row index of the current word
//   io_out_last                   : last row word of the last capture of a frame
//   io_overflow                   : sticky dropped-capture flag
//   io_busy                       : FIFO non-empty after the current edge
// Optional: COLLECTOR_STATS_EN adds io_stat_captures / io_stat_drops (16-bit, saturating).
module stencil_output_collector #(
  parameter int unsigned BW             = stencil_pkg::BW,
  parameter int unsigned ST             = stencil_pkg::ST,
  parameter int unsigned TILES          = stencil_pkg::TILES,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned FRAME_CAPTURES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_datapath_valid_in,
  input  logic [BW-1:0]       io_datapath_data_in1,
  input  logic [BW-1:0]       io_datapath_data_in2,
  input  logic [BW-1:0]       io_datapath_data_in3,
  input  logic [BW-1:0]       io_datapath_data_in4,
  input  logic [BW-1:0]       io_datapath_data_in5,
  input  logic [BW-1:0]       io_datapath_data_in6,
  output logic                io_out_valid,
  input  logic                io_out_ready,
  output logic [TILES*BW-1:0] io_out_data,
  output logic [1:0]          io_out_row,
  output logic                io_out_last,
  output logic                io_overflow,
  output logic                io_busy
`ifdef COLLECTOR_STATS_EN
  ,
  output logic [15:0]         io_stat_captures,
  output logic [15:0]         io_stat_drops
`endif
);

  import stencil_pkg::*;

  localparam int unsigned RW  = TILES*BW;
  localparam int unsigned SW  = ST*TILES*BW;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned FCW = (FRAME_CAPTURES > 1) ? $clog2(FRAME_CAPTURES) : 1;

  out_state_e     state;
  logic [SW-1:0]  cap_set;
  logic [SW-1:0]  head;
  logic [SW-1:0]  head_after_pop;
  logic [AW:0]    count;
  logic [AW:0]    count_next;
  logic           full;
  logic           empty;
  logic           hs;
  logic           pop;
  logic           push;
  logic           more;
  logic [FCW-1:0] frame_cnt;

  assign cap_set = {io_datapath_data_in6, io_datapath_data_in5, io_datapath_data_in4,
                    io_datapath_data_in3, io_datapath_data_in2, io_datapath_data_in1};

  function automatic logic [RW-1:0] row_of(input logic [SW-1:0] s, input int unsigned r);
    return s[r*RW +: RW];
  endfunction

  // Handshake, pop on the final row, push allowed into a full FIFO when it pops
  always_comb begin
    hs         = io_out_valid && io_out_ready;
    pop        = hs && (state == ROW2);
    push       = io_datapath_valid_in && (!full || pop);
    count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    more       = (count_next != '0);
  end

  collector_fifo #(
    .DEPTH (DEPTH),
    .W     (SW)
  ) u_fifo (
    .clock          (clock),
    .reset          (reset),
    .push           (push),
    .pop            (pop),
    .din            (cap_set),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .head           (head),
    .head_after_pop (head_after_pop)
  );

  // Serializer FSM with registered stream outputs computed for the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      io_out_valid <= 1'b0;
      io_out_data  <= '0;
      io_out_row   <= 2'd0;
      io_out_last  <= 1'b0;
      io_overflow  <= 1'b0;
      io_busy      <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      io_busy <= more;
      if (io_datapath_valid_in && !push) io_overflow <= 1'b1;
      if (pop) frame_cnt <= (frame_cnt == FCW'(FRAME_CAPTURES-1)) ? '0 : frame_cnt + FCW'(1);

      case (state)
        IDLE: begin
          // A capture landing on an empty FIFO is presented straight away
          if (push || !empty) begin
            state        <= ROW0;
            io_out_valid <= 1'b1;
            io_out_data  <= row_of(empty ? cap_set : head, 0);
            io_out_row   <= 2'd0;
            io_out_last  <= 1'b0;
          end
        end
        ROW0: begin
          if (hs) begin
            state       <= ROW1;
            io_out_data <= row_of(head, 1);
            io_out_row  <= 2'd1;
          end
        end
        ROW1: begin
          if (hs) begin
            state       <= ROW2;
            io_out_data <= row_of(head, 2);
            io_out_row  <= 2'd2;
            io_out_last <= (frame_cnt == FCW'(FRAME_CAPTURES-1));
          end
        end
        ROW2: begin
          if (hs) begin
            io_out_last <= 1'b0;
            io_out_row  <= 2'd0;
            if (more) begin
              state       <= ROW0;
              io_out_data <= row_of(head_after_pop, 0);
            end else begin
              state        <= IDLE;
              io_out_valid <= 1'b0;
              io_out_data  <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COLLECTOR_STATS_EN
  // Saturating accepted/dropped capture counters
  always_ff @(posedge clock) begin
    if (reset) begin
      io_stat_captures <= 16'h0000;
      io_stat_drops    <= 16'h0000;
    end else begin
      if (push && io_stat_captures != 16'hFFFF) io_stat_captures <= io_stat_captures + 16'd1;
      if (io_datapath_valid_in && !push && io_stat_drops != 16'hFFFF)
        io_stat_drops <= io_stat_drops + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_stencil_output_collector.sv
// Self-checking bench for stencil_output_collector: directed scenarios followed by
// random traffic, all checked against a queue-based model of the row-word stream.
module tb_stencil_output_collector;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        vin;
  logic        ready;
  logic [31:0] din [6];
  logic        io_out_valid;
  logic [63:0] io_out_data;
  logic [1:0]  io_out_row;
  logic        io_out_last;
  logic        io_overflow;
  logic        io_busy;
`ifdef COLLECTOR_STATS_EN
  logic [15:0] io_stat_captures;
  logic [15:0] io_stat_drops;
`endif

  always #5 clock = ~clock;

  stencil_output_collector dut (
    .clock                (clock),
    .reset                (reset),
    .io_datapath_valid_in (vin),
    .io_datapath_data_in1 (din[0]),
    .io_datapath_data_in2 (din[1]),
    .io_datapath_data_in3 (din[2]),
    .io_datapath_data_in4 (din[3]),
    .io_datapath_data_in5 (din[4]),
    .io_datapath_data_in6 (din[5]),
    .io_out_valid         (io_out_valid),
    .io_out_ready         (ready),
    .io_out_data          (io_out_data),
    .io_out_row           (io_out_row),
    .io_out_last          (io_out_last),
    .io_overflow          (io_overflow),
    .io_busy              (io_busy)
`ifdef COLLECTOR_STATS_EN
    ,
    .io_stat_captures     (io_stat_captures),
    .io_stat_drops        (io_stat_drops)
`endif
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  row;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          occ;
  int          cap_idx;
  logic        ovf_m;
  int          cap_m;
  int          drop_m;
  int          checks;
  int          errors;
  int          n_words;
  int          n_last;
  logic [63:0] saved;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < 6; i++) din[i] = $urandom;
  endtask

  // One clock: update the model from the pre-edge inputs, then check post-edge outputs
  task automatic tick();
    logic hs;
    logic pop;
    logic acc;
    exp_t e;
    exp_t w;
    pop = 1'b0;
    if (reset) begin
      exp_q.delete();
      occ = 0; cap_idx = 0; ovf_m = 1'b0; cap_m = 0; drop_m = 0;
    end else begin
      hs = io_out_valid && ready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", 64'(io_out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          pop = (e.row == 2'd2);
          n_words++;
          if (io_out_last) n_last++;
        end
      end
      acc = vin && (occ < int'(DEPTH) || pop);
      if (acc) begin
        for (int r = 0; r < 3; r++) begin
          w.data = {din[2*r+1], din[2*r]};
          w.row  = 2'(r);
          w.last = (r == 2) && ((cap_idx % FRAME) == FRAME - 1);
          exp_q.push_back(w);
        end
        cap_idx++;
        occ++;
        if (cap_m < 16'hFFFF) cap_m++;
      end else if (vin) begin
        ovf_m = 1'b1;
        if (drop_m < 16'hFFFF) drop_m++;
      end
      if (pop) occ--;
    end
    @(posedge clock);
    #1;
    chk("valid", 64'(io_out_valid), 64'(occ != 0));
    chk("busy", 64'(io_busy), 64'(occ != 0));
    chk("overflow", 64'(io_overflow), 64'(ovf_m));
    if (occ != 0 && exp_q.size() > 0) begin
      chk("data", io_out_data, exp_q[0].data);
      chk("row", 64'(io_out_row), 64'(exp_q[0].row));
      chk("last", 64'(io_out_last), 64'(exp_q[0].last));
    end else begin
      chk("idle_last", 64'(io_out_last), 64'(0));
      if (reset) begin
        chk("rst_data", io_out_data, 64'(0));
        chk("rst_row", 64'(io_out_row), 64'(0));
      end
    end
`ifdef COLLECTOR_STATS_EN
    chk("stat_captures", 64'(io_stat_captures), 64'(cap_m));
    chk("stat_drops", 64'(io_stat_drops), 64'(drop_m));
`endif
  endtask

  task automatic drain(input int budget);
    vin   = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < budget && occ != 0; i++) tick();
    chk("drain_done", 64'(io_busy), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vin   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; n_words = 0; n_last = 0;
    occ = 0; cap_idx = 0; ovf_m = 1'b0; cap_m = 0; drop_m = 0;
    reset = 1'b1; vin = 1'b0; ready = 1'b0;
    for (int i = 0; i < 6; i++) din[i] = 32'h0;
    tick();
    tick();
    reset = 1'b0;

    // Single capture, fixed values, ready held high
    din[0] = 32'h3F800000; din[1] = 32'h40000000; din[2] = 32'h40400000;
    din[3] = 32'h40800000; din[4] = 32'h40A00000; din[5] = 32'h40C00000;
    vin = 1'b1; ready = 1'b1;
    tick();
    vin = 1'b0;
    chk("sc_valid_rise", 64'(io_out_valid), 64'(1));
    chk("sc_row0", io_out_data, 64'h40000000_3F800000);
    tick();
    chk("sc_row1", io_out_data, 64'h40800000_40400000);
    chk("sc_row1_idx", 64'(io_out_row), 64'(1));
    tick();
    chk("sc_row2", io_out_data, 64'h40C00000_40A00000);
    chk("sc_row2_idx", 64'(io_out_row), 64'(2));
    tick();
    chk("sc_valid_drop", 64'(io_out_valid), 64'(0));

    // Backpressure holds row0
    rand_data();
    saved = {din[1], din[0]};
    vin = 1'b1; ready = 1'b0;
    tick();
    vin = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_hold_data", io_out_data, saved);
      chk("bp_hold_row", 64'(io_out_row), 64'(0));
    end
    ready = 1'b1;
    tick();
    chk("bp_row1_after_ready", 64'(io_out_row), 64'(1));
    drain(20);

    // Overflow: DEPTH+2 strobes with the stream stalled
    ready = 1'b0;
    repeat (DEPTH + 2) begin
      rand_data();
      vin = 1'b1;
      tick();
    end
    vin = 1'b0;
    chk("ovf_set", 64'(io_overflow), 64'(1));
    n_words = 0;
    drain(60);
    chk("ovf_words", 64'(n_words), 64'(12));

    // Frame last on every FRAME-th capture
    do_reset();
    n_last = 0;
    for (int c = 0; c < 8; c++) begin
      rand_data();
      vin = 1'b1; ready = 1'b1;
      tick();
      drain(20);
    end
    chk("frame_last_count", 64'(n_last), 64'(2));

    // Full FIFO accepts a capture alongside the row2 pop
    do_reset();
    ready = 1'b0;
    repeat (DEPTH) begin
      rand_data();
      vin = 1'b1;
      tick();
    end
    vin = 1'b0;
    n_words = 0;
    ready = 1'b1;
    tick();
    tick();
    chk("fp_at_row2", 64'(io_out_row), 64'(2));
    rand_data();
    vin = 1'b1;
    tick();
    vin = 1'b0;
    chk("fp_no_ovf", 64'(io_overflow), 64'(0));
    drain(60);
    chk("fp_words", 64'(n_words), 64'(15));

    // Reset during row1 of a three-entry FIFO
    do_reset();
    ready = 1'b0;
    repeat (3) begin
      rand_data();
      vin = 1'b1;
      tick();
    end
    vin = 1'b0;
    ready = 1'b1;
    tick();
    chk("rm_row1", 64'(io_out_row), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_valid_low", 64'(io_out_valid), 64'(0));
    n_last = 0;
    for (int c = 0; c < 4; c++) begin
      rand_data();
      vin = 1'b1; ready = 1'b1;
      tick();
      if (c == 0) chk("rm_restart_row0", 64'(io_out_row), 64'(0));
      drain(20);
    end
    chk("rm_frame_last", 64'(n_last), 64'(1));

    // Random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      vin   = $urandom_range(0, 1) == 1;
      ready = $urandom_range(0, 9) < 6;
      rand_data();
      tick();
    end
    reset = 1'b0;
    drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
